// File: rtl/scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
package scanner_pkg;
    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;
    localparam int TMR_W       = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable up-counter; o_term flags when the count reaches i_term.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic         o_term
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)         r_cnt <= '0;
        else if (i_load) r_cnt <= '0;
        else if (i_inc)  r_cnt <= r_cnt + W'(1);
    end

    assign o_term = (r_cnt == i_term);
endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 8 input combinations of a 3-input block, captures y per vector
// and counts disagreements with EXP_MASK.
module truth_table_scanner
    import scanner_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXP_MASK      = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result,
    output logic [3:0] mismatch_cnt
);
    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_result;
    logic [CNT_W-1:0] r_mis;
    logic             w_term;
    logic             w_accept;
    logic             w_last;

    // The timer counts 0..SETTLE_CYCLES-1 while in SETTLE, so it terminates
    // on the SETTLE_CYCLES-th cycle.
    settle_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == DRIVE),
        .i_inc  (r_state == SETTLE),
        .i_term (TMR_W'(SETTLE_CYCLES - 1)),
        .o_term (w_term)
    );

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_idx == IDX_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = DRIVE;
            DRIVE:      w_next = SETTLE;
            SETTLE:     if (w_term) w_next = SAMPLE;
            SAMPLE:     w_next = w_last ? DONE : DRIVE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_result <= '0;
            r_mis    <= '0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_result <= '0;
            r_mis    <= '0;
        end else if (r_state == SAMPLE) begin
            r_result[r_idx] <= y;
            if (y != EXP_MASK[r_idx]) r_mis <= r_mis + CNT_W'(1);
            if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Stimulus is derived from registered state only; idle/done park at 000.
    always_comb begin
        {a, b, c} = 3'b000;
        if (busy) {a, b, c} = r_idx;
    end

    assign busy         = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
    assign done         = (r_state == DONE);
    assign pass         = done && (r_mis == '0);
    assign result       = r_result;
    assign mismatch_cnt = r_mis;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: four scanner configurations run side by side against the
// reference gate Q = C & ~(A|B) & ~(A&B) (or a tied-high response).
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] a, b, c, y, busy, done, pass;
    logic [7:0] res [4];
    logic [3:0] cnt [4];

    // u0: defaults; u1: EXP_MASK=0; u2: y tied high, EXP_MASK=0; u3: SETTLE_CYCLES=5
    assign y[0] = c[0] & ~(a[0] | b[0]) & ~(a[0] & b[0]);
    assign y[1] = c[1] & ~(a[1] | b[1]) & ~(a[1] & b[1]);
    assign y[2] = 1'b1;
    assign y[3] = c[3] & ~(a[3] | b[3]) & ~(a[3] & b[3]);

    truth_table_scanner u0 (
        .clk(clk), .rst(rst), .start(start), .a(a[0]), .b(b[0]), .c(c[0]), .y(y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .result(res[0]), .mismatch_cnt(cnt[0]));
    truth_table_scanner #(.EXP_MASK(8'h00)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a[1]), .b(b[1]), .c(c[1]), .y(y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .result(res[1]), .mismatch_cnt(cnt[1]));
    truth_table_scanner #(.EXP_MASK(8'h00)) u2 (
        .clk(clk), .rst(rst), .start(start), .a(a[2]), .b(b[2]), .c(c[2]), .y(y[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .result(res[2]), .mismatch_cnt(cnt[2]));
    truth_table_scanner #(.SETTLE_CYCLES(5)) u3 (
        .clk(clk), .rst(rst), .start(start), .a(a[3]), .b(b[3]), .c(c[3]), .y(y[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .result(res[3]), .mismatch_cnt(cnt[3]));

    typedef struct {
        string      name;
        int         dut;
        int         done_cyc;
        logic [7:0] result;
        logic [3:0] mis;
        logic       pass;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int done_cyc [4];
    int abc_cnt [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one accepting edge; on return we sit #1 after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run up to budget cycles after the accepting edge, logging when each
    // DUT first shows done; optionally re-pulse start at cycle 10.
    task automatic run_scan(input int budget, input bit repulse);
        for (int i = 0; i < 4; i++) done_cyc[i] = -1;
        for (int k = 0; k < 8; k++) abc_cnt[k] = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (busy[3]) abc_cnt[{a[3], b[3], c[3]}]++;
            if (repulse && cyc == 10) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < 4; i++)
                if (done[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
        end
    endtask

    vec_t tbl [4];

    initial begin
        tbl[0] = '{"default",   0, 32, 8'h02, 4'd0, 1'b1};
        tbl[1] = '{"exp00",     1, 32, 8'h02, 4'd1, 1'b0};
        tbl[2] = '{"y_high",    2, 32, 8'hFF, 4'd8, 1'b0};
        tbl[3] = '{"settle5",   3, 56, 8'h02, 4'd0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy[0], 0);
        chk("reset_done", done[0], 0);
        chk("reset_pass", pass[0], 0);
        chk("reset_result", res[0], 0);
        chk("reset_cnt", cnt[0], 0);
        chk("reset_abc", {a[0], b[0], c[0]}, 0);
        rst = 1'b0;

        pulse_start();
        chk("accept_busy", busy[0], 1);
        run_scan(70, 1'b1);
        for (int t = 0; t < 4; t++) begin
            chk({tbl[t].name, "_done_cyc"}, done_cyc[tbl[t].dut], tbl[t].done_cyc);
            chk({tbl[t].name, "_result"}, res[tbl[t].dut], tbl[t].result);
            chk({tbl[t].name, "_mis"}, cnt[tbl[t].dut], tbl[t].mis);
            chk({tbl[t].name, "_pass"}, pass[tbl[t].dut], tbl[t].pass);
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("settle5_abc_hold_%0d", k), abc_cnt[k], 7);
        chk("done_held_busy", busy[0], 0);
        chk("done_idle_abc", {a[0], b[0], c[0]}, 0);

        pulse_start();
        chk("restart_done", done[0], 0);
        chk("restart_busy", busy[0], 1);
        chk("restart_result", res[0], 0);
        chk("restart_cnt", cnt[1], 0);
        run_scan(60, 1'b0);
        chk("rescan_done_cyc", done_cyc[0], 32);
        chk("rescan_result", res[0], 8'h02);
        chk("rescan_pass", pass[0], 1);

        pulse_start();
        repeat (15) @(posedge clk);
        #1;
        chk("midscan_busy", busy[0], 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_pass", pass[0], 0);
        chk("abort_result", res[0], 0);
        chk("abort_cnt", cnt[2], 0);
        chk("abort_abc", {a[0], b[0], c[0]}, 0);
        run_scan(40, 1'b0);
        chk("abort_no_done", done_cyc[0], -1);
        chk("abort_still_idle", busy[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
